// File: rtl/bel_csplit_if.sv
// Stream bundle for bel_csplit: x/y complex pair in, recovered a/b complex pair out.
// master drives operands and ready_i; slave is the splitter.
interface bel_csplit_if #(
  parameter int word_width = 16
);
  logic signed [word_width-1:0] x_re_i;
  logic signed [word_width-1:0] x_im_i;
  logic signed [word_width-1:0] y_re_i;
  logic signed [word_width-1:0] y_im_i;
  logic                         inv_i;
  logic                         last_i;
  logic                         valid_i;
  logic                         ready_o;
  logic signed [word_width-1:0] a_re_o;
  logic signed [word_width-1:0] a_im_o;
  logic signed [word_width-1:0] b_re_o;
  logic signed [word_width-1:0] b_im_o;
  logic                         last_o;
  logic                         valid_o;
  logic                         ready_i;

  modport master (
    output x_re_i, x_im_i, y_re_i, y_im_i, inv_i, last_i, valid_i, ready_i,
    input  ready_o, a_re_o, a_im_o, b_re_o, b_im_o, last_o, valid_o
  );

  modport slave (
    input  x_re_i, x_im_i, y_re_i, y_im_i, inv_i, last_i, valid_i, ready_i,
    output ready_o, a_re_o, a_im_o, b_re_o, b_im_o, last_o, valid_o
  );
endinterface

// File: rtl/bel_csplit.sv
// Splits x = a -/+ j*b, y = a +/- j*b into a = (x+y)/2, b = j*(x-y)/2; 2-cycle latency.
// Valid/ready with combinational ready_o: full rate when flowing, stalls hold both stages.
module bel_csplit #(
  parameter int word_width = 16,
  parameter bit round_en   = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  bel_csplit_if.slave  bus
);
  localparam int W = word_width;

  typedef logic signed [W:0]   wide_t;
  typedef logic signed [W-1:0] word_t;

  typedef struct packed {
    wide_t sa_re;
    wide_t sa_im;
    wide_t sb_re;
    wide_t sb_im;
    logic  last;
  } s1_t;

  typedef struct packed {
    word_t a_re;
    word_t a_im;
    word_t b_re;
    word_t b_im;
    logic  last;
  } s2_t;

  localparam wide_t Rnd = wide_t'(round_en ? 1 : 0);

  function automatic wide_t sext(input word_t v);
    return {v[W-1], v};
  endfunction

  // Bits [W:1] of the (W+1)-bit sum equal the arithmetic shift taken to W bits;
  // a carry out of the sum would only reach bit W+1, which is dropped anyway.
  function automatic word_t halve(input wide_t s);
    wide_t t;
    t = s + Rnd;
    return t[W:1];
  endfunction

  logic  s1_vld_q, s1_vld_d;
  logic  s2_vld_q, s2_vld_d;
  s1_t   s1_q, s1_d;
  s2_t   s2_q, s2_d;
  logic  s2_load, s1_load, accept;

  wide_t x_re_w, x_im_w, y_re_w, y_im_w;

  assign x_re_w = sext(bus.x_re_i);
  assign x_im_w = sext(bus.x_im_i);
  assign y_re_w = sext(bus.y_re_i);
  assign y_im_w = sext(bus.y_im_i);

  always_comb begin
    s2_load  = !s2_vld_q || bus.ready_i;
    s1_load  = !s1_vld_q || s2_load;
    accept   = bus.valid_i && s1_load;

    s1_vld_d = s1_vld_q;
    s1_d     = s1_q;
    s2_vld_d = s2_vld_q;
    s2_d     = s2_q;

    if (s1_load) begin
      s1_vld_d = bus.valid_i;
      if (accept) begin
        s1_d.sa_re = x_re_w + y_re_w;
        s1_d.sa_im = x_im_w + y_im_w;
        // inv_i swaps the roles of x and y, which just negates both differences
        if (!bus.inv_i) begin
          s1_d.sb_re = y_im_w - x_im_w;
          s1_d.sb_im = x_re_w - y_re_w;
        end else begin
          s1_d.sb_re = x_im_w - y_im_w;
          s1_d.sb_im = y_re_w - x_re_w;
        end
        s1_d.last = bus.last_i;
      end
    end

    if (s2_load) begin
      s2_vld_d = s1_vld_q;
      if (s1_vld_q) begin
        s2_d.a_re = halve(s1_q.sa_re);
        s2_d.a_im = halve(s1_q.sa_im);
        s2_d.b_re = halve(s1_q.sb_re);
        s2_d.b_im = halve(s1_q.sb_im);
        s2_d.last = s1_q.last;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld_q <= 1'b0;
      s2_vld_q <= 1'b0;
      s1_q     <= '0;
      s2_q     <= '0;
    end else begin
      s1_vld_q <= s1_vld_d;
      s2_vld_q <= s2_vld_d;
      s1_q     <= s1_d;
      s2_q     <= s2_d;
    end
  end

  assign bus.ready_o = s1_load;
  assign bus.valid_o = s2_vld_q;
  assign bus.a_re_o  = s2_q.a_re;
  assign bus.a_im_o  = s2_q.a_im;
  assign bus.b_re_o  = s2_q.b_re;
  assign bus.b_im_o  = s2_q.b_im;
  assign bus.last_o  = s2_q.last;

  a_out_stable: assert property (@(posedge clk) disable iff (rst)
    (bus.valid_o && !bus.ready_i) |=> (bus.valid_o && $stable(s2_q)));
endmodule

// File: tb/tb_bel_csplit.sv
// Directed bench for bel_csplit: one rounding and one truncating instance driven in lockstep.
module tb_bel_csplit;
  typedef struct packed {
    logic signed [15:0] ar;
    logic signed [15:0] ai;
    logic signed [15:0] br;
    logic signed [15:0] bi;
    logic               last;
  } out_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk  = 0;
  int   n_pass = 0;

  always #5 clk = ~clk;

  bel_csplit_if #(.word_width(16)) bus_r ();
  bel_csplit_if #(.word_width(16)) bus_t ();

  bel_csplit #(.word_width(16), .round_en(1'b1)) dut_r (.clk(clk), .rst(rst), .bus(bus_r));
  bel_csplit #(.word_width(16), .round_en(1'b0)) dut_t (.clk(clk), .rst(rst), .bus(bus_t));

  task automatic drv(input logic signed [15:0] xr, xi, yr, yi, input logic inv, lst, vld);
    bus_r.x_re_i = xr; bus_r.x_im_i = xi; bus_r.y_re_i = yr; bus_r.y_im_i = yi;
    bus_r.inv_i = inv; bus_r.last_i = lst; bus_r.valid_i = vld;
    bus_t.x_re_i = xr; bus_t.x_im_i = xi; bus_t.y_re_i = yr; bus_t.y_im_i = yi;
    bus_t.inv_i = inv; bus_t.last_i = lst; bus_t.valid_i = vld;
  endtask

  task automatic set_rdy(input logic r);
    bus_r.ready_i = r;
    bus_t.ready_i = r;
  endtask

  function automatic out_t grab_r();
    return {bus_r.a_re_o, bus_r.a_im_o, bus_r.b_re_o, bus_r.b_im_o, bus_r.last_o};
  endfunction

  function automatic out_t grab_t();
    return {bus_t.a_re_o, bus_t.a_im_o, bus_t.b_re_o, bus_t.b_im_o, bus_t.last_o};
  endfunction

  function automatic string fmt(input out_t o);
    return $sformatf("a=(%0d,%0d) b=(%0d,%0d) last=%0b", o.ar, o.ai, o.br, o.bi, o.last);
  endfunction

  function automatic out_t mk(input int ar, ai, br, bi, input logic lst);
    out_t o;
    o.ar = 16'(ar); o.ai = 16'(ai); o.br = 16'(br); o.bi = 16'(bi); o.last = lst;
    return o;
  endfunction

  // One isolated beat at full rate: samples ready at offer, valid one and two edges after accept.
  task automatic run_beat(input logic signed [15:0] xr, xi, yr, yi, input logic inv,
                          output logic rdy, v_early, v_on, output out_t o_r, o_t);
    @(posedge clk); #1;
    set_rdy(1'b1);
    drv(xr, xi, yr, yi, inv, 1'b0, 1'b1);
    @(negedge clk); rdy = bus_r.ready_o;
    @(posedge clk); #1;
    drv(0, 0, 0, 0, 1'b0, 1'b0, 1'b0);
    @(negedge clk); v_early = bus_r.valid_o;
    @(negedge clk); v_on = bus_r.valid_o; o_r = grab_r(); o_t = grab_t();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    set_rdy(1'b1);
    drv(0, 0, 0, 0, 1'b0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_chk++; if (bus_r.valid_o !== 1'b0) $display("FAIL reset_valid got %b want 0", bus_r.valid_o); else n_pass++;
    n_chk++; if (bus_r.last_o !== 1'b0) $display("FAIL reset_last got %b want 0", bus_r.last_o); else n_pass++;
    n_chk++; if (grab_r() !== mk(0, 0, 0, 0, 1'b0)) $display("FAIL reset_data got %s want zeros", fmt(grab_r())); else n_pass++;
    n_chk++; if (bus_r.ready_o !== 1'b1) $display("FAIL reset_ready got %b want 1", bus_r.ready_o); else n_pass++;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_basic();
    logic rdy, ve, vo;
    out_t o_r, o_t, e;
    e = mk(100, -50, 30, 7, 1'b0);
    run_beat(107, -80, 93, -20, 1'b0, rdy, ve, vo, o_r, o_t);
    n_chk++; if (rdy !== 1'b1) $display("FAIL basic_ready got %b want 1", rdy); else n_pass++;
    n_chk++; if (ve !== 1'b0) $display("FAIL basic_latency_early got valid %b want 0", ve); else n_pass++;
    n_chk++; if (vo !== 1'b1) $display("FAIL basic_latency got valid %b want 1", vo); else n_pass++;
    n_chk++; if (o_r !== e) $display("FAIL basic_round got %s want %s", fmt(o_r), fmt(e)); else n_pass++;
    n_chk++; if (o_t !== e) $display("FAIL basic_trunc got %s want %s", fmt(o_t), fmt(e)); else n_pass++;
  endtask

  task automatic test_inv();
    logic rdy, ve, vo;
    out_t o_r, o_t, e;
    e = mk(100, -50, 30, 7, 1'b0);
    run_beat(93, -20, 107, -80, 1'b1, rdy, ve, vo, o_r, o_t);
    n_chk++; if (vo !== 1'b1) $display("FAIL inv_valid got %b want 1", vo); else n_pass++;
    n_chk++; if (o_r !== e) $display("FAIL inv_round got %s want %s", fmt(o_r), fmt(e)); else n_pass++;
    n_chk++; if (o_t !== e) $display("FAIL inv_trunc got %s want %s", fmt(o_t), fmt(e)); else n_pass++;
  endtask

  task automatic test_rounding();
    logic rdy, ve, vo;
    out_t o_r, o_t, e_r, e_t;
    // sum 3 and difference -1
    run_beat(1, 0, 2, 0, 1'b0, rdy, ve, vo, o_r, o_t);
    e_r = mk(2, 0, 0, 0, 1'b0);
    e_t = mk(1, 0, 0, -1, 1'b0);
    n_chk++; if (o_r !== e_r) $display("FAIL odd_pos_round got %s want %s", fmt(o_r), fmt(e_r)); else n_pass++;
    n_chk++; if (o_t !== e_t) $display("FAIL odd_pos_trunc got %s want %s", fmt(o_t), fmt(e_t)); else n_pass++;
    // sum -3 and difference -3
    run_beat(-3, 0, 0, 0, 1'b0, rdy, ve, vo, o_r, o_t);
    e_r = mk(-1, 0, 0, -1, 1'b0);
    e_t = mk(-2, 0, 0, -2, 1'b0);
    n_chk++; if (o_r !== e_r) $display("FAIL odd_neg_round got %s want %s", fmt(o_r), fmt(e_r)); else n_pass++;
    n_chk++; if (o_t !== e_t) $display("FAIL odd_neg_trunc got %s want %s", fmt(o_t), fmt(e_t)); else n_pass++;
  endtask

  task automatic test_extreme();
    logic rdy, ve, vo;
    out_t o_r, o_t, e;
    e = mk(32767, -32768, 0, 0, 1'b0);
    run_beat(16'sh7fff, 16'sh8000, 16'sh7fff, 16'sh8000, 1'b0, rdy, ve, vo, o_r, o_t);
    n_chk++; if (o_r !== e) $display("FAIL extreme_round got %s want %s", fmt(o_r), fmt(e)); else n_pass++;
    n_chk++; if (o_t !== e) $display("FAIL extreme_trunc got %s want %s", fmt(o_t), fmt(e)); else n_pass++;
  endtask

  task automatic test_stream();
    logic [3:0] pat = 4'b1001;
    out_t q[$];
    out_t cur, held, e;
    logic hold = 1'b0;
    logic pres = 1'b0;
    int   sent = 0, got = 0, cyc = 0, extra = 0;
    logic signed [15:0] xr, xi, yr, yi;
    while (got < 8 && cyc < 400) begin
      @(posedge clk); #1;
      set_rdy(pat[cyc % 4]);
      if (!pres && sent < 8 && $urandom_range(0, 1) == 1) begin
        e  = mk(10 * (sent + 1), -3 * (sent + 1), (sent + 1) + 20, 2 * (sent + 1) - 5, sent == 7);
        // x = a - j*b, y = a + j*b; odd beats present them swapped with inv_i=1
        xr = e.ar + e.bi; xi = e.ai - e.br;
        yr = e.ar - e.bi; yi = e.ai + e.br;
        if (sent % 2 == 0) drv(yr, yi, xr, xi, 1'b1, e.last, 1'b1);
        else               drv(xr, xi, yr, yi, 1'b0, e.last, 1'b1);
        pres = 1'b1;
      end else if (!pres) begin
        drv(0, 0, 0, 0, 1'b0, 1'b0, 1'b0);
      end
      @(negedge clk);
      cur = grab_r();
      if (hold) begin
        n_chk++;
        if (bus_r.valid_o !== 1'b1 || cur !== held) $display("FAIL stall_stable got v=%b %s want %s", bus_r.valid_o, fmt(cur), fmt(held));
        else n_pass++;
      end
      hold = bus_r.valid_o && !bus_r.ready_i;
      held = cur;
      if (bus_r.valid_o && bus_r.ready_i) begin
        n_chk++;
        if (q.size() == 0) $display("FAIL stream_extra got %s want nothing", fmt(cur));
        else begin
          out_t x;
          x = q.pop_front();
          if (cur !== x) $display("FAIL stream_beat%0d got %s want %s", got + 1, fmt(cur), fmt(x));
          else n_pass++;
        end
        got++;
      end
      if (pres && bus_r.ready_o) begin
        q.push_back(e);
        sent++;
        pres = 1'b0;
      end
      cyc++;
    end
    n_chk++; if (got !== 8) $display("FAIL stream_count got %0d want 8", got); else n_pass++;
    @(posedge clk); #1;
    set_rdy(1'b1);
    drv(0, 0, 0, 0, 1'b0, 1'b0, 1'b0);
    repeat (3) begin
      @(negedge clk);
      if (bus_r.valid_o) extra++;
    end
    n_chk++; if (extra !== 0) $display("FAIL stream_dup got %0d extra beats want 0", extra); else n_pass++;
  endtask

  task automatic test_fill();
    @(posedge clk); #1;
    set_rdy(1'b0);
    drv(10, 0, 10, 0, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    n_chk++; if (bus_r.ready_o !== 1'b1) $display("FAIL fill_rdy1 got %b want 1", bus_r.ready_o); else n_pass++;
    @(posedge clk); #1;
    drv(20, 0, 20, 0, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    n_chk++; if (bus_r.ready_o !== 1'b1) $display("FAIL fill_rdy2 got %b want 1", bus_r.ready_o); else n_pass++;
    @(posedge clk); #1;
    drv(30, 0, 30, 0, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    n_chk++; if (bus_r.ready_o !== 1'b0) $display("FAIL fill_full got ready %b want 0", bus_r.ready_o); else n_pass++;
    n_chk++; if (bus_r.valid_o !== 1'b1 || bus_r.a_re_o !== 16'sd10) $display("FAIL fill_head got v=%b a_re=%0d want v=1 a_re=10", bus_r.valid_o, bus_r.a_re_o); else n_pass++;
    @(posedge clk); #1;
    @(negedge clk);
    n_chk++; if (bus_r.ready_o !== 1'b0 || bus_r.a_re_o !== 16'sd10) $display("FAIL fill_hold got ready=%b a_re=%0d want 0 10", bus_r.ready_o, bus_r.a_re_o); else n_pass++;
    @(posedge clk); #1;
    set_rdy(1'b1);
    @(negedge clk);
    n_chk++; if (bus_r.ready_o !== 1'b1) $display("FAIL fill_release got ready %b want 1", bus_r.ready_o); else n_pass++;
    @(posedge clk); #1;
    drv(40, 0, 40, 0, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    n_chk++; if (bus_r.valid_o !== 1'b1 || bus_r.a_re_o !== 16'sd20 || bus_r.ready_o !== 1'b1) $display("FAIL fill_out2 got v=%b a_re=%0d rdy=%b want 1 20 1", bus_r.valid_o, bus_r.a_re_o, bus_r.ready_o); else n_pass++;
    @(posedge clk); #1;
    drv(0, 0, 0, 0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    n_chk++; if (bus_r.valid_o !== 1'b1 || bus_r.a_re_o !== 16'sd30) $display("FAIL fill_out3 got v=%b a_re=%0d want 1 30", bus_r.valid_o, bus_r.a_re_o); else n_pass++;
    @(negedge clk);
    n_chk++; if (bus_r.valid_o !== 1'b1 || bus_r.a_re_o !== 16'sd40) $display("FAIL fill_out4 got v=%b a_re=%0d want 1 40", bus_r.valid_o, bus_r.a_re_o); else n_pass++;
    @(negedge clk);
    n_chk++; if (bus_r.valid_o !== 1'b0) $display("FAIL fill_drain got valid %b want 0", bus_r.valid_o); else n_pass++;
  endtask

  task automatic test_reset_flight();
    int seen = 0;
    logic rdy, ve, vo;
    out_t o_r, o_t;
    @(posedge clk); #1;
    set_rdy(1'b0);
    drv(50, 0, 50, 0, 1'b0, 1'b1, 1'b1);
    @(posedge clk); #1;
    drv(60, 0, 60, 0, 1'b0, 1'b1, 1'b1);
    @(posedge clk); #1;
    rst = 1'b1;
    drv(0, 0, 0, 0, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    set_rdy(1'b1);
    @(negedge clk);
    n_chk++; if (bus_r.valid_o !== 1'b0) $display("FAIL flight_valid got %b want 0", bus_r.valid_o); else n_pass++;
    n_chk++; if (bus_r.ready_o !== 1'b1) $display("FAIL flight_ready got %b want 1", bus_r.ready_o); else n_pass++;
    repeat (4) begin
      @(negedge clk);
      if (bus_r.valid_o) seen++;
    end
    n_chk++; if (seen !== 0) $display("FAIL flight_stale got %0d beats want 0", seen); else n_pass++;
    run_beat(70, 0, 70, 0, 1'b0, rdy, ve, vo, o_r, o_t);
    n_chk++; if (vo !== 1'b1 || o_r !== mk(70, 0, 0, 0, 1'b0)) $display("FAIL flight_new got v=%b %s want a=(70,0) b=(0,0) last=0", vo, fmt(o_r)); else n_pass++;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic();
    test_inv();
    test_rounding();
    test_extreme();
    test_stream();
    test_fill();
    test_reset_flight();
    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
